dispatch_router: RTL
====================

Name: dispatch_router

Overview:
- Front end of the issue-queue protocol: the transmitter that drives inst_valid / queue_ready and the instruction fields into the per-FU issue queues.
- Accepts renamed instructions from rename through an in-order FIFO and steers each head entry to the issue queue of its target FU.
- Keeps a PRN readiness scoreboard, cleared on destination allocation and set by FU writeback broadcasts, and uses it to generate prn_input_ready at dispatch.

Parameters:
- INST_ID_BITS, 6, instruction id width
- PRN_BITS, 6, physical register number width; the scoreboard holds 2**PRN_BITS entries
- MAX_OPERANDS, 3, source and destination slots per instruction
- FU_COUNT, 4, number of FU/issue-queue pairs
- DEPTH, 8, dispatch FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  pipeline flush
- in_valid  in  1  rename offers an instruction
- in_ready  out  1  router accepts
- in_inst_id  in  INST_ID_BITS  instruction id
- in_raw_instr  in  32  instruction word
- in_pc  in  64  instruction PC
- in_fu_sel  in  $clog2(FU_COUNT)  target FU index
- in_prn_input_valid  in  MAX_OPERANDS  source slot valid
- in_prn_input  in  MAX_OPERANDS*PRN_BITS  source PRNs
- in_prn_output_valid  in  MAX_OPERANDS  destination slot valid
- in_prn_output  in  MAX_OPERANDS*PRN_BITS  destination PRNs
- set_prn_ready  in  FU_COUNT*MAX_OPERANDS  writeback broadcast valids
- set_prn  in  FU_COUNT*MAX_OPERANDS*PRN_BITS  writeback broadcast PRNs
- inst_valid  out  FU_COUNT  one-hot dispatch valid per issue queue
- queue_ready  in  FU_COUNT  issue queue can accept
- inst_id, raw_instr, instr_pc  out  INST_ID_BITS/32/64  head fields, shared by all queues
- prn_input_valid, prn_input, prn_output_valid, prn_output  out  as the in_ versions  head operand fields
- prn_input_ready  out  MAX_OPERANDS  source operand already produced

Behaviour:
- Reset: FIFO empty (count=0); all scoreboard bits = 1 (ready); inst_valid = 0; in_ready = 1.
  - The shared data outputs are don't-care while inst_valid = 0.
- Enqueue: occurs when in_valid && in_ready.
  - in_ready = (count < DEPTH) and depends only on registered state.
  - There is no bypass: an instruction enqueued in cycle N can dispatch no earlier than cycle N+1.
- Dispatch handshake: inst_valid[k] = (count != 0) && (head.fu_sel == k).
  - inst_valid never depends on queue_ready.
  - Transfer happens on the clk edge where inst_valid[k] && queue_ready[k]; the head then pops.
  - At most one transfer per cycle. Dispatch is strictly in order; head-of-line blocking is intended.
  - Data outputs hold stable while inst_valid is asserted and the transfer has not happened.
- Simultaneous enqueue and dequeue: count is unchanged and the pointers both advance.
  - Enqueue and dequeue cannot coincide when full, because in_ready = 0.
- Pointers wrap modulo DEPTH.
- Scoreboard clear: on enqueue, every in_prn_output slot with its valid bit set clears its scoreboard bit at that edge.
- Scoreboard set: every set_prn_ready bit that is 1 sets the scoreboard bit for its set_prn at the edge.
- Same PRN set and cleared in one cycle: the clear wins.
- prn_input_ready[j] = !prn_input_valid[j] OR sb[prn_input[j]] OR (a same-cycle set_prn match on prn_input[j]).
  - This term is combinational so the broadcast is not lost in the dispatch cycle.
- Flush:
  - FIFO empties at the edge (count=0).
  - Any enqueue or dispatch in that cycle is discarded, so inst_valid must not be counted as a transfer.
  - All scoreboard bits are set to 1.
  - Set/clear traffic in the flush cycle is ignored.
- Out-of-range in_fu_sel (≥ FU_COUNT): the entry is enqueued normally. At the head it drives no inst_valid and pops unconditionally in one cycle.
- rst asserted mid-operation: immediate return to reset state; in-flight entries are lost.

Test Plan:
- Reset, then enqueue one instruction with fu_sel=2 and queue_ready=4'b1111 → in_ready=1 at reset; inst_valid=4'b0100 exactly one cycle later; pop on that edge; inst_valid=0 the following cycle.
- Hold queue_ready[1]=0 and enqueue 8 instructions with fu_sel=1 → count reaches 8; in_ready=0; outputs stable. Release queue_ready → 8 dispatches in consecutive cycles in original inst_id order, including pointer wrap.
- Enqueue A (dest PRN 17), then B (source PRN 17), with B stalled → B shows prn_input_ready=0. Pulse set_prn=17 while B is presented → prn_input_ready=1 in that same cycle, and it stays 1 afterwards.
- Same-cycle enqueue clearing PRN 9 and broadcast setting PRN 9 → scoreboard bit 9 = 0 afterwards.
- Full FIFO with a queue transfer and in_valid both high → no enqueue that cycle (in_ready=0); enqueue accepted the next cycle; count returns to 8.
- Flush with 5 queued entries and 3 PRNs not ready → inst_valid=0 and count=0 next cycle, all prn_input_ready=1. Assert rst asynchronously mid-dispatch → outputs clear without waiting for a clock edge.

Source files
------------

// File: rtl/dispatch_router_if.sv
// Signal bundle between rename, the dispatch router, FU writeback broadcasts and the issue queues.
interface dispatch_router_if #(
    parameter int unsigned INST_ID_BITS = 6,
    parameter int unsigned PRN_BITS     = 6,
    parameter int unsigned MAX_OPERANDS = 3,
    parameter int unsigned FU_COUNT     = 4
);
    localparam int unsigned FU_SEL_W = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
    localparam int unsigned OPS_W    = MAX_OPERANDS * PRN_BITS;
    localparam int unsigned N_SET    = FU_COUNT * MAX_OPERANDS;

    logic                    in_valid;
    logic                    in_ready;
    logic [INST_ID_BITS-1:0] in_inst_id;
    logic [31:0]             in_raw_instr;
    logic [63:0]             in_pc;
    logic [FU_SEL_W-1:0]     in_fu_sel;
    logic [MAX_OPERANDS-1:0] in_prn_input_valid;
    logic [OPS_W-1:0]        in_prn_input;
    logic [MAX_OPERANDS-1:0] in_prn_output_valid;
    logic [OPS_W-1:0]        in_prn_output;

    logic [N_SET-1:0]          set_prn_ready;
    logic [N_SET*PRN_BITS-1:0] set_prn;

    logic [FU_COUNT-1:0]     inst_valid;
    logic [FU_COUNT-1:0]     queue_ready;
    logic [INST_ID_BITS-1:0] inst_id;
    logic [31:0]             raw_instr;
    logic [63:0]             instr_pc;
    logic [MAX_OPERANDS-1:0] prn_input_valid;
    logic [OPS_W-1:0]        prn_input;
    logic [MAX_OPERANDS-1:0] prn_output_valid;
    logic [OPS_W-1:0]        prn_output;
    logic [MAX_OPERANDS-1:0] prn_input_ready;

    // Router side
    modport slave (
        input  in_valid, in_inst_id, in_raw_instr, in_pc, in_fu_sel,
               in_prn_input_valid, in_prn_input, in_prn_output_valid, in_prn_output,
               set_prn_ready, set_prn, queue_ready,
        output in_ready, inst_valid, inst_id, raw_instr, instr_pc,
               prn_input_valid, prn_input, prn_output_valid, prn_output, prn_input_ready
    );

    // Environment side (rename, writeback, issue queues)
    modport master (
        output in_valid, in_inst_id, in_raw_instr, in_pc, in_fu_sel,
               in_prn_input_valid, in_prn_input, in_prn_output_valid, in_prn_output,
               set_prn_ready, set_prn, queue_ready,
        input  in_ready, inst_valid, inst_id, raw_instr, instr_pc,
               prn_input_valid, prn_input, prn_output_valid, prn_output, prn_input_ready
    );
endinterface

// File: rtl/dispatch_router.sv
// In-order dispatch FIFO steering head instructions to per-FU issue queues,
// with a PRN readiness scoreboard feeding prn_input_ready.
module dispatch_router #(
    parameter int unsigned INST_ID_BITS = 6,
    parameter int unsigned PRN_BITS     = 6,
    parameter int unsigned MAX_OPERANDS = 3,
    parameter int unsigned FU_COUNT     = 4,
    parameter int unsigned DEPTH        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    dispatch_router_if.slave bus
);
    localparam int unsigned FU_SEL_W = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
    localparam int unsigned OPS_W    = MAX_OPERANDS * PRN_BITS;
    localparam int unsigned N_SET    = FU_COUNT * MAX_OPERANDS;
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned SB_SIZE  = 2 ** PRN_BITS;

    typedef struct packed {
        logic [INST_ID_BITS-1:0] inst_id;
        logic [31:0]             raw_instr;
        logic [63:0]             pc;
        logic [FU_SEL_W-1:0]     fu_sel;
        logic [MAX_OPERANDS-1:0] src_valid;
        logic [OPS_W-1:0]        src;
        logic [MAX_OPERANDS-1:0] dst_valid;
        logic [OPS_W-1:0]        dst;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [SB_SIZE-1:0] r_sb;

    entry_t                  w_in;
    entry_t                  w_head;
    logic                    w_in_ready;
    logic                    w_nonempty;
    logic                    w_fu_ok;
    logic                    w_head_rdy;
    logic                    w_push;
    logic                    w_pop;
    logic [FU_COUNT-1:0]     w_inst_valid;
    logic [MAX_OPERANDS-1:0] w_src_rdy;
    logic [SB_SIZE-1:0]      w_sb_next;

    assign w_in = '{
        inst_id:   bus.in_inst_id,
        raw_instr: bus.in_raw_instr,
        pc:        bus.in_pc,
        fu_sel:    bus.in_fu_sel,
        src_valid: bus.in_prn_input_valid,
        src:       bus.in_prn_input,
        dst_valid: bus.in_prn_output_valid,
        dst:       bus.in_prn_output
    };

    assign w_head     = r_mem[r_rd_ptr];
    assign w_nonempty = (r_count != '0);
    assign w_in_ready = (r_count < CNT_W'(DEPTH));
    assign w_fu_ok    = (32'(w_head.fu_sel) < FU_COUNT);
    // Heads with no matching FU drain without a handshake
    assign w_head_rdy = !w_fu_ok || bus.queue_ready[w_head.fu_sel];
    assign w_pop      = w_nonempty && w_head_rdy && !flush;
    assign w_push     = bus.in_valid && w_in_ready && !flush;

    always_comb begin
        w_inst_valid = '0;
        for (int unsigned k = 0; k < FU_COUNT; k++) begin
            w_inst_valid[k] = w_nonempty && (32'(w_head.fu_sel) == k);
        end
    end

    // Same-cycle broadcasts count as ready so a wakeup is not missed at dispatch
    always_comb begin
        w_src_rdy = '0;
        for (int unsigned j = 0; j < MAX_OPERANDS; j++) begin
            w_src_rdy[j] = !w_head.src_valid[j] || r_sb[w_head.src[j*PRN_BITS +: PRN_BITS]];
            for (int unsigned i = 0; i < N_SET; i++) begin
                if (bus.set_prn_ready[i] &&
                    (bus.set_prn[i*PRN_BITS +: PRN_BITS] == w_head.src[j*PRN_BITS +: PRN_BITS])) begin
                    w_src_rdy[j] = 1'b1;
                end
            end
        end
    end

    // Sets first, then allocation clears so a clear beats a same-cycle set
    always_comb begin
        w_sb_next = r_sb;
        for (int unsigned i = 0; i < N_SET; i++) begin
            if (bus.set_prn_ready[i]) begin
                w_sb_next[bus.set_prn[i*PRN_BITS +: PRN_BITS]] = 1'b1;
            end
        end
        if (w_push) begin
            for (int unsigned j = 0; j < MAX_OPERANDS; j++) begin
                if (bus.in_prn_output_valid[j]) begin
                    w_sb_next[bus.in_prn_output[j*PRN_BITS +: PRN_BITS]] = 1'b0;
                end
            end
        end
        if (flush) begin
            w_sb_next = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_sb     <= '1;
        end else begin
            r_sb <= w_sb_next;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    // Payload storage needs no reset; validity is tracked by r_count
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_in;
    end

    assign bus.in_ready         = w_in_ready;
    assign bus.inst_valid       = w_inst_valid;
    assign bus.inst_id          = w_head.inst_id;
    assign bus.raw_instr        = w_head.raw_instr;
    assign bus.instr_pc         = w_head.pc;
    assign bus.prn_input_valid  = w_head.src_valid;
    assign bus.prn_input        = w_head.src;
    assign bus.prn_output_valid = w_head.dst_valid;
    assign bus.prn_output       = w_head.dst;
    assign bus.prn_input_ready  = w_src_rdy;

endmodule
